// File: rtl/bht_two_bit_predictor.sv
// Branch history table of 2-bit saturating counters with optional gshare-style
// global history folded into the index. Lookup is combinational; updates land on clk.
module bht_two_bit_predictor #(
  parameter int         num_addr_bits = 5,
  parameter int         ghr_bits      = 0,
  parameter logic [1:0] init_state    = 2'b01,
  localparam int        GHR_W         = (ghr_bits > 0) ? ghr_bits : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      mem_address_IF,
  input  logic             br_instruction,
  output logic             prediction,
  input  logic [15:0]      mem_address_WB,
  input  logic             taken,
  input  logic             not_taken,
  output logic [GHR_W-1:0] ghr_out,
  output logic [15:0]      update_count
);

  localparam int ENTRIES = 1 << num_addr_bits;

  logic [1:0]               r_table [0:ENTRIES-1];
  logic [GHR_W-1:0]         r_ghr;
  logic [15:0]              r_update_count;

  logic [num_addr_bits-1:0] w_ghr_ext;
  logic [num_addr_bits-1:0] w_if_idx;
  logic [num_addr_bits-1:0] w_wb_idx;
  logic [GHR_W-1:0]         w_ghr_next;
  logic                     w_upd_taken;
  logic                     w_upd_not_taken;
  logic                     w_upd_any;
  logic [1:0]               w_if_entry;
  logic [1:0]               w_wb_entry;
  logic [3:0]               w_unused_addr;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    if (c == 2'b11) begin
      sat_inc = 2'b11;
    end else begin
      sat_inc = c + 2'b01;
    end
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    if (c == 2'b00) begin
      sat_dec = 2'b00;
    end else begin
      sat_dec = c - 2'b01;
    end
  endfunction

  // Word-aligned PC bits and bits above the index never reach the table.
  assign w_unused_addr = {mem_address_IF[0], mem_address_WB[0],
                          ^mem_address_IF[15:num_addr_bits+1],
                          ^mem_address_WB[15:num_addr_bits+1]};

  always_comb begin
    w_ghr_ext              = '0;
    w_ghr_ext[GHR_W-1:0]   = r_ghr;
  end

  assign w_if_idx = mem_address_IF[num_addr_bits:1] ^ w_ghr_ext;
  assign w_wb_idx = mem_address_WB[num_addr_bits:1] ^ w_ghr_ext;

  assign w_upd_taken     = taken & ~not_taken;
  assign w_upd_not_taken = not_taken & ~taken;
  assign w_upd_any       = w_upd_taken | w_upd_not_taken;

  // History shift; with no history configured the register stays pinned at zero.
  generate
    if (ghr_bits > 1) begin : g_ghr_multi
      assign w_ghr_next = {r_ghr[GHR_W-2:0], taken};
    end else if (ghr_bits == 1) begin : g_ghr_single
      assign w_ghr_next = taken;
    end else begin : g_ghr_none
      assign w_ghr_next = '0;
    end
  endgenerate

  assign w_if_entry = r_table[w_if_idx];
  assign w_wb_entry = r_table[w_wb_idx];

  // Reads see the pre-update counter; writes become visible next cycle.
  assign prediction   = br_instruction & w_if_entry[1];
  assign ghr_out      = r_ghr;
  assign update_count = r_update_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= init_state;
      end
    end else if (w_upd_taken) begin
      r_table[w_wb_idx] <= sat_inc(w_wb_entry);
    end else if (w_upd_not_taken) begin
      r_table[w_wb_idx] <= sat_dec(w_wb_entry);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ghr          <= '0;
      r_update_count <= 16'h0000;
    end else if (w_upd_any) begin
      r_ghr          <= w_ghr_next;
      r_update_count <= r_update_count + 16'h0001;
    end
  end

endmodule
